// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning the HI/LO registers.
// Implements MULT, MULTU, DIV and DIVU with a radix-2 shift-add multiplier
// and a restoring shift-subtract divider, one step per clock.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   start, op         request pulse (sampled in IDLE) and operation select
//                     (00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   a, b              rs/rt operands (multiplicand/dividend, multiplier/divisor)
//   hi_we, lo_we      MTHI/MTLO write enables, honoured only in IDLE
//   wdata             MTHI/MTLO write data
//   busy              operation in flight
//   done              one-cycle pulse when an operation updates HI/LO
//   div_by_zero       set with done for a divide by zero, held until next start
//   hi, lo            architectural HI/LO registers
module muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW  = $clog2(WIDTH) + 1;
    localparam int unsigned AW  = 2 * WIDTH;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]       state,       state_nxt;
    logic [CW-1:0]    counter,     counter_nxt;
    logic [1:0]       op_q,        op_nxt;
    logic             sign_a,      sign_a_nxt;
    logic             sign_b,      sign_b_nxt;
    logic [WIDTH-1:0] opnd,        opnd_nxt;     // multiplicand or divisor magnitude
    logic [WIDTH-1:0] a_raw,       a_raw_nxt;    // original dividend for divide-by-zero
    logic [AW-1:0]    acc,         acc_nxt;      // product, or {remainder, quotient}
    logic             busy_nxt;
    logic             done_nxt;
    logic             dbz_nxt;
    logic [WIDTH-1:0] hi_nxt;
    logic [WIDTH-1:0] lo_nxt;

    // Operand magnitudes at the accepting edge; unsigned ops pass raw values.
    logic             in_sign_a;
    logic             in_sign_b;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    assign in_sign_a = ~op[0] & a[WIDTH-1];
    assign in_sign_b = ~op[0] & b[WIDTH-1];
    assign mag_a     = in_sign_a ? WIDTH'(WIDTH'(0) - a) : a;
    assign mag_b     = in_sign_b ? WIDTH'(WIDTH'(0) - b) : b;

    // Multiply step: conditionally add multiplicand to the upper half, shift right.
    logic [WIDTH:0]   mul_sum;
    logic [AW-1:0]    mul_step;

    assign mul_sum  = {1'b0, acc[AW-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    assign mul_step = {mul_sum, acc[WIDTH-1:1]};

    // Restoring divide step: shift next dividend bit into the remainder, trial subtract.
    logic [WIDTH:0]   div_sh;
    logic             div_ge;
    logic [WIDTH:0]   div_rem;
    logic [AW-1:0]    div_step;

    assign div_sh   = {acc[AW-1:WIDTH], acc[WIDTH-1]};
    assign div_ge   = div_sh >= {1'b0, opnd};
    assign div_rem  = div_ge ? (WIDTH+1)'(div_sh - {1'b0, opnd}) : div_sh;
    assign div_step = {div_rem[WIDTH-1:0], acc[WIDTH-2:0], div_ge};

    // Sign correction applied in FIX; sign flags are zero for unsigned ops.
    logic             res_neg;
    logic [AW-1:0]    prod_fix;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;
    logic             div_zero;

    assign res_neg  = sign_a ^ sign_b;
    assign prod_fix = res_neg ? AW'(AW'(0) - acc) : acc;
    assign quo_fix  = res_neg ? WIDTH'(WIDTH'(0) - acc[WIDTH-1:0]) : acc[WIDTH-1:0];
    assign rem_fix  = sign_a ? WIDTH'(WIDTH'(0) - acc[AW-1:WIDTH]) : acc[AW-1:WIDTH];
    assign div_zero = (opnd == '0);

    // Next-state and next-register values.
    always_comb begin
        state_nxt   = state;
        counter_nxt = counter;
        op_nxt      = op_q;
        sign_a_nxt  = sign_a;
        sign_b_nxt  = sign_b;
        opnd_nxt    = opnd;
        a_raw_nxt   = a_raw;
        acc_nxt     = acc;
        busy_nxt    = busy;
        done_nxt    = 1'b0;
        dbz_nxt     = div_by_zero;
        hi_nxt      = hi;
        lo_nxt      = lo;

        case (state)
            S_IDLE: begin
                if (hi_we) hi_nxt = wdata;
                if (lo_we) lo_nxt = wdata;
                if (start) begin
                    op_nxt      = op;
                    sign_a_nxt  = in_sign_a;
                    sign_b_nxt  = in_sign_b;
                    a_raw_nxt   = a;
                    opnd_nxt    = op[1] ? mag_b : mag_a;
                    acc_nxt     = op[1] ? {{WIDTH{1'b0}}, mag_a} : {{WIDTH{1'b0}}, mag_b};
                    counter_nxt = '0;
                    busy_nxt    = 1'b1;
                    dbz_nxt     = 1'b0;
                    state_nxt   = S_CALC;
                end
            end
            S_CALC: begin
                acc_nxt     = op_q[1] ? div_step : mul_step;
                counter_nxt = CW'(counter + 1'b1);
                if (counter == CW'(WIDTH - 1)) state_nxt = S_FIX;
            end
            S_FIX: begin
                if (!op_q[1]) begin
                    hi_nxt = prod_fix[AW-1:WIDTH];
                    lo_nxt = prod_fix[WIDTH-1:0];
                end else if (div_zero) begin
                    hi_nxt  = a_raw;
                    lo_nxt  = '1;
                    dbz_nxt = 1'b1;
                end else begin
                    hi_nxt = rem_fix;
                    lo_nxt = quo_fix;
                end
                done_nxt  = 1'b1;
                busy_nxt  = 1'b0;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    // State and register update; reset discards any in-flight operation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            counter     <= '0;
            op_q        <= '0;
            sign_a      <= 1'b0;
            sign_b      <= 1'b0;
            opnd        <= '0;
            a_raw       <= '0;
            acc         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            state       <= state_nxt;
            counter     <= counter_nxt;
            op_q        <= op_nxt;
            sign_a      <= sign_a_nxt;
            sign_b      <= sign_b_nxt;
            opnd        <= opnd_nxt;
            a_raw       <= a_raw_nxt;
            acc         <= acc_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
            div_by_zero <= dbz_nxt;
            hi          <= hi_nxt;
            lo          <= lo_nxt;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus randomized
// operations compared against a plain-arithmetic reference model.
module tb_muldiv_unit;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         hi_we;
    logic         lo_we;
    logic [W-1:0] wdata;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .hi_we       (hi_we),
        .lo_we       (lo_we),
        .wdata       (wdata),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference architectural state.
    logic [W-1:0] m_hi  = '0;
    logic [W-1:0] m_lo  = '0;
    logic         m_dbz = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Result of an operation computed with ordinary 64-bit arithmetic.
    task automatic model_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        longint      sx;
        longint      sy;
        longint      q;
        longint      r;
        logic [63:0] p;
        sx    = longint'($signed(x));
        sy    = longint'($signed(y));
        m_dbz = 1'b0;
        case (o)
            2'b00: begin
                p    = 64'(sx * sy);
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
            2'b01: begin
                p    = {32'd0, x} * {32'd0, y};
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
            default: begin
                if (y == '0) begin
                    m_lo  = '1;
                    m_hi  = x;
                    m_dbz = 1'b1;
                end else if (o == 2'b10) begin
                    q    = sx / sy;
                    r    = sx % sy;
                    m_lo = q[31:0];
                    m_hi = r[31:0];
                end else begin
                    m_lo = x / y;
                    m_hi = x % y;
                end
            end
        endcase
    endtask

    // Issue one operation, optionally disturbing it mid-flight with a second
    // start and an MTHI, and check latency, busy, done and the results.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input bit disturb);
        int got_k;
        got_k = 0;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom;
        check_eq({tag, " busy_after_accept"}, 64'(busy), 64'd1);
        check_eq({tag, " dbz_cleared"}, 64'(div_by_zero), 64'd0);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (disturb && k == 10) begin
                start = 1'b1; op = 2'b11; a = 32'd9; b = 32'd3;
                hi_we = 1'b1; wdata = 32'h0000_AAAA;
            end
            if (disturb && k == 11) begin
                start = 1'b0; hi_we = 1'b0;
            end
            if (k == 16) check_eq({tag, " hi_stable"}, 64'(hi), 64'(m_hi));
            if (k == 32) check_eq({tag, " busy_late"}, 64'(busy), 64'd1);
            if (done) begin
                got_k = k;
                break;
            end
        end
        start = 1'b0; hi_we = 1'b0;
        model_op(o, x, y);
        check_eq({tag, " latency"}, 64'(got_k), 64'd33);
        check_eq({tag, " busy_at_done"}, 64'(busy), 64'd0);
        check_eq({tag, " hi"}, 64'(hi), 64'(m_hi));
        check_eq({tag, " lo"}, 64'(lo), 64'(m_lo));
        check_eq({tag, " dbz"}, 64'(div_by_zero), 64'(m_dbz));
        @(negedge clk);
        check_eq({tag, " done_pulse"}, 64'(done), 64'd0);
    endtask

    task automatic count_done(input string tag, input int cycles);
        int seen;
        seen = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (done) seen++;
        end
        check_eq({tag, " no_extra_done"}, 64'(seen), 64'd0);
    endtask

    initial begin
        logic [1:0]   ro;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        int           sel;

        reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        repeat (3) @(negedge clk);
        check_eq("reset busy", 64'(busy), 64'd0);
        check_eq("reset done", 64'(done), 64'd0);
        check_eq("reset dbz", 64'(div_by_zero), 64'd0);
        check_eq("reset hi", 64'(hi), 64'd0);
        check_eq("reset lo", 64'(lo), 64'd0);
        reset = 1'b0;

        // Directed cases.
        run_op("mult_7_m3", 2'b00, 32'd7, 32'hFFFF_FFFD, 1'b0);
        check_eq("mult_7_m3 hi_const", 64'(hi), 64'hFFFF_FFFF);
        check_eq("mult_7_m3 lo_const", 64'(lo), 64'hFFFF_FFEB);
        run_op("multu_ff", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check_eq("multu_ff hi_const", 64'(hi), 64'hFFFF_FFFE);
        run_op("mult_ff", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check_eq("mult_ff lo_const", 64'(lo), 64'd1);
        run_op("div_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
        check_eq("div_m7_2 lo_const", 64'(lo), 64'hFFFF_FFFD);
        run_op("divu_100_7", 2'b11, 32'd100, 32'd7, 1'b0);
        check_eq("divu_100_7 lo_const", 64'(lo), 64'd14);
        run_op("divu_by0", 2'b11, 32'd100, 32'd0, 1'b0);
        repeat (3) @(negedge clk);
        check_eq("divu_by0 dbz_held", 64'(div_by_zero), 64'd1);
        run_op("multu_3_4", 2'b01, 32'd3, 32'd4, 1'b0);
        run_op("div_overflow", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check_eq("div_overflow lo_const", 64'(lo), 64'h8000_0000);
        run_op("div_by0_neg", 2'b10, 32'hFFFF_FF00, 32'd0, 1'b0);

        // Start and MTHI while busy are dropped.
        run_op("overlap", 2'b01, 32'd5, 32'd6, 1'b1);
        count_done("overlap", 40);
        check_eq("overlap hi_final", 64'(hi), 64'd0);

        // MTLO in IDLE.
        @(negedge clk);
        lo_we = 1'b1; wdata = 32'h1234;
        @(negedge clk);
        lo_we = 1'b0;
        m_lo = 32'h1234;
        check_eq("mtlo lo", 64'(lo), 64'h1234);
        check_eq("mtlo hi_kept", 64'(hi), 64'(m_hi));

        // Reset mid-operation discards it.
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h55;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        check_eq("mt55 hi", 64'(hi), 64'h55);
        check_eq("mt55 lo", 64'(lo), 64'h55);
        start = 1'b1; op = 2'b00; a = 32'd1234; b = 32'd5678;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        #1;
        check_eq("midreset hi", 64'(hi), 64'd0);
        check_eq("midreset lo", 64'(lo), 64'd0);
        check_eq("midreset busy", 64'(busy), 64'd0);
        m_hi = '0; m_lo = '0; m_dbz = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        count_done("after_reset", 40);
        run_op("div_20_m3", 2'b10, 32'd20, 32'hFFFF_FFFD, 1'b0);
        check_eq("div_20_m3 lo_const", 64'(lo), 64'hFFFF_FFFA);
        check_eq("div_20_m3 hi_const", 64'(hi), 64'd2);

        // Randomized operations, with occasional MT writes and corner operands.
        for (int i = 0; i < 40; i++) begin
            ro  = 2'($urandom_range(0, 3));
            sel = $urandom_range(0, 9);
            ra  = $urandom;
            rb  = $urandom;
            if (sel == 0) rb = '0;
            if (sel == 1) begin ra = $urandom_range(0, 255); rb = $urandom_range(1, 15); end
            if (sel == 2) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            if (sel == 3) rb = 32'($urandom_range(0, 7)) - 32'd4;
            if (sel == 4) begin
                @(negedge clk);
                hi_we = 1'b1; wdata = $urandom;
                @(negedge clk);
                hi_we = 1'b0;
                m_hi = wdata;
                check_eq("rand mthi", 64'(hi), 64'(m_hi));
            end
            run_op($sformatf("rand%0d_op%0d", i, ro), ro, ra, rb, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
